pool_ctrl_mc: RTL and testbench
===============================

Name: pool_ctrl_mc

Overview:
- Multi-channel, mode-configurable pooling controller between the POL feature buffer and the downstream consumer.
- Per pooling request it accepts one base index and issues the K neighbour addresses.
- It receives the K feature beats that come back, each NUM_CH lanes wide.
- It reduces them per lane by max or average and emits one pooled beat.
- Successor to the single-channel fixed-K max-pool controller: adds runtime K, lane count, avg mode, signedness and addr/data overlap.

Parameters:
- NUM_CH, 8, channels (lanes) per feature beat
- DATA_WIDTH, 8, bits per lane
- K_WIDTH, 6, max pool size 2^K_WIDTH (64)
- ADDR_WIDTH, 16, index/address width

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- CfgK  in  K_WIDTH+1  pool size; 0 treated as 1
- CfgMode  in  1  0=max, 1=avg
- CfgSigned  in  1  lanes are two's complement
- CfgShift  in  4  avg right-shift; values >K_WIDTH clamp to K_WIDTH
- IdxVld  in  1  base index valid
- Idx  in  ADDR_WIDTH  base index
- IdxRdy  out  1  ready for new request
- AddrVld  out  1  address valid
- Addr  out  ADDR_WIDTH  neighbour address
- AddrRdy  in  1  address accepted
- FmInVld  in  1  feature beat valid
- FmIn  in  NUM_CH*DATA_WIDTH  feature beat, lane i at bits [i*DATA_WIDTH +: DATA_WIDTH]
- FmInRdy  out  1  beat accepted
- FmOutVld  out  1  pooled beat valid
- FmOut  out  NUM_CH*DATA_WIDTH  pooled beat
- FmOutRdy  in  1  pooled beat taken
- Busy  out  1  state != IDLE

Behaviour:
- One clock domain (clk); rst is synchronous, active-high.
- Handshake fires on Vld&Rdy in the same cycle; Rdy/Vld may depend combinationally on state/counters only, never on the partner's Vld/Rdy.
- States: IDLE, RUN, OUT.
- IDLE: IdxRdy=1.
  - On Idx fire, latch Idx as base, plus CfgK (Klat, 0->1), CfgMode, CfgSigned and CfgShift (clamped).
  - Clear addr_cnt and fm_cnt, then go to RUN.
  - Cfg inputs are ignored at all other times.
- RUN, address side: AddrVld = (addr_cnt < Klat); Addr = base + addr_cnt, modulo 2^ADDR_WIDTH (wraps). addr_cnt increments on each Addr fire.
- RUN, data side: FmInRdy = (fm_cnt < Klat) && (fm_cnt < addr_cnt), using the registered addr_cnt.
  - A beat is never accepted before its address has issued.
  - An address fire and a data fire in the same cycle are both legal.
- Accumulator: per lane, width DATA_WIDTH+K_WIDTH.
  - On the beat with fm_cnt==0, load the lane value, sign- or zero-extended per CfgSigned.
  - Later beats, max mode: acc = max(acc, lane), signed or unsigned compare.
  - Later beats, avg mode: acc = acc + ext(lane). Cannot overflow by construction.
- fm_cnt increments per fire. The fire that makes fm_cnt==Klat moves to OUT next cycle; the accumulator is complete at that point.
- OUT: FmOutVld=1; IdxRdy=0; FmInRdy=0; AddrVld=0.
  - Max mode: FmOut lane = acc[DATA_WIDTH-1:0].
  - Avg mode: FmOut lane = acc >> shift (arithmetic if signed), saturated to the DATA_WIDTH range: unsigned [0,2^DW-1], signed [-2^(DW-1), 2^(DW-1)-1].
  - FmOut is registered and held stable while FmOutVld && !FmOutRdy.
  - On FmOut fire, go to IDLE.
- Throughput:
  - Minimum latency from Idx fire to FmOutVld is Klat+2 cycles, with AddrRdy and FmInVld held high.
  - Back-to-back requests need one IDLE cycle.
- Reset:
  - Cycle rst is high and the next edge: state=IDLE; addr_cnt, fm_cnt, acc, latched cfg, base and FmOut reg all 0.
  - IdxRdy, AddrVld, FmInRdy and FmOutVld are forced to 0 while rst=1.
  - IdxRdy=1 from the first cycle after rst deasserts.
  - Reset mid-RUN or mid-OUT abandons the request; no partial output is ever produced.
- Busy = (state != IDLE).

Test Plan:
- Defaults; max unsigned, K=4, Idx=0x0100, AddrRdy=1, FmInVld=1 -> Addr 0x0100..0x0103 on 4 consecutive cycles; lane0 beats 3,200,17,255 -> exactly one FmOut beat, lane0=255.
- Max signed, K=3:
  - Lane0 beats 0x80,0xF0,0x05 -> 0x05.
  - Lane1 beats 0x80,0xF0,0x90 -> 0xF0.
- Avg:
  - Signed, K=4, shift 2: lane0 10,20,30,41 -> 25 (0x19); lane1 -10,-20,-30,-41 -> -26 (0xE6).
  - Unsigned, K=4, shift 0, all lanes 255 -> every lane saturates to 255.
- Backpressure:
  - AddrRdy toggles 1/0, FmInVld has random gaps, FmOutRdy is held low 5 cycles.
  - FmInRdy is never 1 while fm_cnt==addr_cnt.
  - FmOut is stable for the 5 stalled cycles; IdxRdy=0 until the output fires.
- Boundaries:
  - Idx=0xFFFE, K=4 -> Addr FFFE, FFFF, 0000, 0001.
  - CfgK=0 -> one address issued, one beat accepted, FmOut equals that beat.
  - K=64 -> 64 addresses, output after the 64th beat.
- Reset mid-op:
  - rst pulsed after 2 of 4 beats -> AddrVld, FmInRdy and FmOutVld are 0 in the rst cycle; IdxRdy=1 the cycle after.
  - A new max request over all-zero beats then returns 0, with no stale accumulator value.

Source files
------------

// File: rtl/pool_ctrl_mc.sv
// Multi-channel pooling controller: issues K neighbour addresses per request,
// reduces the returning feature beats per lane by max or average, emits one beat.
module pool_ctrl_mc #(
    parameter int NUM_CH     = 8,
    parameter int DATA_WIDTH = 8,
    parameter int K_WIDTH    = 6,
    parameter int ADDR_WIDTH = 16
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic [K_WIDTH:0]               CfgK,
    input  logic                           CfgMode,
    input  logic                           CfgSigned,
    input  logic [3:0]                     CfgShift,
    input  logic                           IdxVld,
    input  logic [ADDR_WIDTH-1:0]          Idx,
    output logic                           IdxRdy,
    output logic                           AddrVld,
    output logic [ADDR_WIDTH-1:0]          Addr,
    input  logic                           AddrRdy,
    input  logic                           FmInVld,
    input  logic [NUM_CH*DATA_WIDTH-1:0]   FmIn,
    output logic                           FmInRdy,
    output logic                           FmOutVld,
    output logic [NUM_CH*DATA_WIDTH-1:0]   FmOut,
    input  logic                           FmOutRdy,
    output logic                           Busy
);

    localparam int ACC_W = DATA_WIDTH + K_WIDTH;
    localparam int CNT_W = K_WIDTH + 1;
    localparam logic [CNT_W-1:0] K_MAX  = {1'b1, {K_WIDTH{1'b0}}};
    localparam logic [CNT_W-1:0] K_ONE  = CNT_W'(1);
    localparam logic [3:0]       SH_MAX = 4'(K_WIDTH);
    localparam logic signed [ACC_W:0] S_MAX = {{(K_WIDTH+2){1'b0}}, {(DATA_WIDTH-1){1'b1}}};
    localparam logic signed [ACC_W:0] S_MIN = {{(K_WIDTH+2){1'b1}}, {(DATA_WIDTH-1){1'b0}}};
    localparam logic signed [ACC_W:0] U_MAX = {{(K_WIDTH+1){1'b0}}, {DATA_WIDTH{1'b1}}};

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_OUT} state_t;

    state_t                          state_q, state_d;
    logic [ADDR_WIDTH-1:0]           base_q, base_d;
    logic [CNT_W-1:0]                klat_q, klat_d;
    logic                            mode_q, mode_d;
    logic                            sgn_q, sgn_d;
    logic [3:0]                      shift_q, shift_d;
    logic [CNT_W-1:0]                addr_cnt_q, addr_cnt_d;
    logic [CNT_W-1:0]                fm_cnt_q, fm_cnt_d;
    logic [ACC_W-1:0]                acc_q [NUM_CH];
    logic [ACC_W-1:0]                acc_d [NUM_CH];
    logic [ACC_W-1:0]                lane_v;
    logic [NUM_CH*DATA_WIDTH-1:0]    fmout_q, fmout_d;
    logic                            idx_fire, addr_fire, fm_fire, out_fire, last_fire;

    function automatic logic [ACC_W-1:0] lane_ext(input logic [DATA_WIDTH-1:0] v,
                                                  input logic sgn);
        return sgn ? {{K_WIDTH{v[DATA_WIDTH-1]}}, v} : {{K_WIDTH{1'b0}}, v};
    endfunction

    function automatic logic [ACC_W-1:0] lane_max(input logic [ACC_W-1:0] a,
                                                  input logic [ACC_W-1:0] b,
                                                  input logic sgn);
        logic a_ge;
        a_ge = sgn ? ($signed(a) >= $signed(b)) : (a >= b);
        return a_ge ? a : b;
    endfunction

    // One extra headroom bit lets signed and unsigned sums share one saturating compare.
    function automatic logic [DATA_WIDTH-1:0] avg_sat(input logic [ACC_W-1:0] acc,
                                                      input logic [3:0] sh,
                                                      input logic sgn);
        logic signed [ACC_W:0] wide;
        logic signed [ACC_W:0] shv;
        wide = sgn ? $signed({acc[ACC_W-1], acc}) : $signed({1'b0, acc});
        shv  = wide >>> sh;
        if (sgn) begin
            if (shv > S_MAX) return S_MAX[DATA_WIDTH-1:0];
            if (shv < S_MIN) return S_MIN[DATA_WIDTH-1:0];
        end else if (shv > U_MAX) begin
            return U_MAX[DATA_WIDTH-1:0];
        end
        return shv[DATA_WIDTH-1:0];
    endfunction

    assign idx_fire  = IdxVld && IdxRdy;
    assign addr_fire = AddrVld && AddrRdy;
    assign fm_fire   = FmInVld && FmInRdy;
    assign out_fire  = FmOutVld && FmOutRdy;
    assign last_fire = fm_fire && ((fm_cnt_q + K_ONE) == klat_q);

    assign Addr  = base_q + ADDR_WIDTH'(addr_cnt_q);
    assign FmOut = fmout_q;
    assign Busy  = (state_q != S_IDLE);

    always_ff @(posedge clk) begin
        if (rst) state_q <= S_IDLE;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (idx_fire)  state_d = S_RUN;
            S_RUN:   if (last_fire) state_d = S_OUT;
            S_OUT:   if (out_fire)  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Handshake outputs depend only on state and counters, and are muted during reset.
    always_comb begin
        IdxRdy   = 1'b0;
        AddrVld  = 1'b0;
        FmInRdy  = 1'b0;
        FmOutVld = 1'b0;
        if (!rst) begin
            case (state_q)
                S_IDLE: IdxRdy = 1'b1;
                S_RUN: begin
                    AddrVld = (addr_cnt_q < klat_q);
                    FmInRdy = (fm_cnt_q < klat_q) && (fm_cnt_q < addr_cnt_q);
                end
                S_OUT:   FmOutVld = 1'b1;
                default: ;
            endcase
        end
    end

    // Request latch; CfgK above 2^K_WIDTH is clamped so the accumulator cannot overflow.
    always_comb begin
        base_d     = base_q;
        klat_d     = klat_q;
        mode_d     = mode_q;
        sgn_d      = sgn_q;
        shift_d    = shift_q;
        addr_cnt_d = addr_cnt_q;
        fm_cnt_d   = fm_cnt_q;
        if (idx_fire) begin
            base_d     = Idx;
            klat_d     = (CfgK == '0) ? K_ONE : ((CfgK > K_MAX) ? K_MAX : CfgK);
            mode_d     = CfgMode;
            sgn_d      = CfgSigned;
            shift_d    = (CfgShift > SH_MAX) ? SH_MAX : CfgShift;
            addr_cnt_d = '0;
            fm_cnt_d   = '0;
        end
        if (addr_fire) addr_cnt_d = addr_cnt_q + K_ONE;
        if (fm_fire)   fm_cnt_d   = fm_cnt_q + K_ONE;
    end

    always_comb begin
        lane_v  = '0;
        fmout_d = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            lane_v = lane_ext(FmIn[i*DATA_WIDTH +: DATA_WIDTH], sgn_q);
            if (fm_cnt_q == '0)  acc_d[i] = lane_v;
            else if (mode_q)     acc_d[i] = acc_q[i] + lane_v;
            else                 acc_d[i] = lane_max(acc_q[i], lane_v, sgn_q);
            fmout_d[i*DATA_WIDTH +: DATA_WIDTH] = mode_q ? avg_sat(acc_d[i], shift_q, sgn_q)
                                                         : acc_d[i][DATA_WIDTH-1:0];
        end
    end

    // The output register captures the reduced beat on the final accepted input beat.
    always_ff @(posedge clk) begin
        if (rst) begin
            base_q     <= '0;
            klat_q     <= '0;
            mode_q     <= 1'b0;
            sgn_q      <= 1'b0;
            shift_q    <= '0;
            addr_cnt_q <= '0;
            fm_cnt_q   <= '0;
            fmout_q    <= '0;
            for (int i = 0; i < NUM_CH; i++) acc_q[i] <= '0;
        end else begin
            base_q     <= base_d;
            klat_q     <= klat_d;
            mode_q     <= mode_d;
            sgn_q      <= sgn_d;
            shift_q    <= shift_d;
            addr_cnt_q <= addr_cnt_d;
            fm_cnt_q   <= fm_cnt_d;
            if (fm_fire) begin
                for (int i = 0; i < NUM_CH; i++) acc_q[i] <= acc_d[i];
            end
            if (last_fire) fmout_q <= fmout_d;
        end
    end

endmodule

// File: tb/tb_pool_ctrl_mc.sv
// Directed bench for pool_ctrl_mc: expected addresses and pooled beats go into
// queues that independent negedge monitors drain as the DUT presents them.
module tb_pool_ctrl_mc;
    localparam int NC = 8, DW = 8, KW = 6, AW = 16;

    logic              clk = 1'b0;
    logic              rst;
    logic [KW:0]       CfgK;
    logic              CfgMode, CfgSigned;
    logic [3:0]        CfgShift;
    logic              IdxVld, IdxRdy;
    logic [AW-1:0]     Idx, Addr;
    logic              AddrVld, AddrRdy;
    logic              FmInVld, FmInRdy, FmOutVld, FmOutRdy, Busy;
    logic [NC*DW-1:0]  FmIn, FmOut;

    int nchk = 0;
    int nerr = 0;
    logic [AW-1:0]    exp_addr_q[$];
    logic [63:0]      exp_out_q[$];
    logic [63:0]      beats[$];

    pool_ctrl_mc #(.NUM_CH(NC), .DATA_WIDTH(DW), .K_WIDTH(KW), .ADDR_WIDTH(AW)) dut (
        .clk(clk), .rst(rst), .CfgK(CfgK), .CfgMode(CfgMode), .CfgSigned(CfgSigned),
        .CfgShift(CfgShift), .IdxVld(IdxVld), .Idx(Idx), .IdxRdy(IdxRdy),
        .AddrVld(AddrVld), .Addr(Addr), .AddrRdy(AddrRdy), .FmInVld(FmInVld),
        .FmIn(FmIn), .FmInRdy(FmInRdy), .FmOutVld(FmOutVld), .FmOut(FmOut),
        .FmOutRdy(FmOutRdy), .Busy(Busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        nchk++;
        if (act !== req) begin
            nerr++;
            $display("FAIL %s actual=%h required=%h", name, act, req);
        end
    endtask

    always @(negedge clk) begin
        if (AddrVld === 1'b1 && AddrRdy === 1'b1) begin
            if (exp_addr_q.size() == 0) begin
                nchk++; nerr++;
                $display("FAIL addr_unexpected actual=%h required=none", Addr);
            end else begin
                check("addr", 64'(Addr), 64'(exp_addr_q.pop_front()));
            end
        end
        if (FmOutVld === 1'b1 && FmOutRdy === 1'b1) begin
            if (exp_out_q.size() == 0) begin
                nchk++; nerr++;
                $display("FAIL fmout_unexpected actual=%h required=none", FmOut);
            end else begin
                check("fmout", FmOut, exp_out_q.pop_front());
            end
        end
    end

    task automatic run_req(input logic [AW-1:0] idx, input logic [KW:0] k, input logic mode,
                           input logic sgn, input logic [3:0] sh, input logic [63:0] expv,
                           input bit bp, input bit lat_chk, input int abort_after);
        int nk, na, nb, cyc, lat, stall;
        bit done, aborted, seen, a_f, d_f;
        logic [63:0] held;
        nk = (k == 0) ? 1 : int'(k);
        for (int i = 0; i < nk; i++) exp_addr_q.push_back(idx + AW'(i));
        if (abort_after < 0) exp_out_q.push_back(expv);
        cyc = 0;
        while (IdxRdy !== 1'b1 && cyc < 50) begin @(posedge clk); #1; cyc++; end
        check("idxrdy_wait", 64'(IdxRdy), 64'd1);
        Idx = idx; CfgK = k; CfgMode = mode; CfgSigned = sgn; CfgShift = sh; IdxVld = 1'b1;
        @(posedge clk); #1;
        IdxVld = 1'b0; CfgK = 7'd9; CfgMode = ~mode; CfgSigned = ~sgn; CfgShift = 4'd1;
        AddrRdy = 1'b1; FmInVld = 1'b1; FmOutRdy = bp ? 1'b0 : 1'b1;
        FmIn = (beats.size() > 0) ? beats[0] : '0;
        na = 0; nb = 0; cyc = 0; lat = 1; stall = 0; held = '0;
        done = 0; aborted = 0; seen = 0;
        while (cyc < 3000) begin
            @(negedge clk);
            a_f = AddrVld && AddrRdy;
            d_f = FmInVld && FmInRdy;
            if (FmInRdy) check("fminrdy_after_addr", 64'(nb < na), 64'd1);
            if (FmOutVld) begin
                if (lat_chk && !seen) check("latency", 64'(lat), 64'(nk + 2));
                seen = 1;
                if (bp) begin
                    if (stall > 0) begin
                        check("fmout_stable", FmOut, held);
                        check("idxrdy_stall", 64'(IdxRdy), 64'd0);
                    end
                    held = FmOut;
                    stall++;
                end
                if (FmOutRdy) begin done = 1; break; end
            end
            @(posedge clk); #1;
            cyc++; lat++;
            if (a_f) na++;
            if (d_f) begin nb++; beats.delete(0); end
            FmIn = (beats.size() > 0) ? beats[0] : '0;
            if (bp) begin
                AddrRdy = ~AddrRdy;
                FmInVld = 1'($urandom_range(0, 1));
                if (stall >= 5) FmOutRdy = 1'b1;
            end
            if (abort_after >= 0 && nb == abort_after) begin aborted = 1; break; end
        end
        if (aborted) begin
            exp_addr_q.delete();
            rst = 1'b1; AddrRdy = 1'b1; FmInVld = 1'b1; FmOutRdy = 1'b1;
            @(negedge clk);
            check("rst_addrvld", 64'(AddrVld), 64'd0);
            check("rst_fminrdy", 64'(FmInRdy), 64'd0);
            check("rst_fmoutvld", 64'(FmOutVld), 64'd0);
            check("rst_idxrdy", 64'(IdxRdy), 64'd0);
            @(posedge clk); #1;
            rst = 1'b0; AddrRdy = 1'b0; FmInVld = 1'b0;
            @(negedge clk);
            check("idxrdy_after_abort", 64'(IdxRdy), 64'd1);
            beats.delete();
        end else if (done) begin
            @(posedge clk); #1;
            AddrRdy = 1'b0; FmInVld = 1'b0; FmOutRdy = 1'b1;
            check("busy_idle", 64'(Busy), 64'd0);
        end else begin
            nchk++; nerr++;
            $display("FAIL timeout actual=%0d cycles required=output", cyc);
        end
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog actual=running required=finished");
        $fatal(1);
    end

    initial begin
        rst = 1'b1; IdxVld = 1'b0; Idx = '0; CfgK = '0; CfgMode = 1'b0; CfgSigned = 1'b0;
        CfgShift = '0; AddrRdy = 1'b0; FmInVld = 1'b0; FmIn = '0; FmOutRdy = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("reset_idxrdy", 64'(IdxRdy), 64'd0);
        check("reset_addrvld", 64'(AddrVld), 64'd0);
        check("reset_fminrdy", 64'(FmInRdy), 64'd0);
        check("reset_fmoutvld", 64'(FmOutVld), 64'd0);
        check("reset_busy", 64'(Busy), 64'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        check("idxrdy_after_reset", 64'(IdxRdy), 64'd1);

        // max unsigned, K=4: lane0 3,200,17,255 -> 255
        beats = '{64'h03, 64'hC8, 64'h11, 64'hFF};
        run_req(16'h0100, 7'd4, 1'b0, 1'b0, 4'd0, 64'h0000_0000_0000_00FF, 0, 1, -1);

        // max signed, K=3: lane0 -> 0x05, lane1 -> 0xF0
        beats = '{64'h8080, 64'hF0F0, 64'h9005};
        run_req(16'h0200, 7'd3, 1'b0, 1'b1, 4'd0, 64'h0000_0000_0000_F005, 0, 0, -1);

        // avg signed, K=4, shift 2: lane0 25 (0x19), lane1 -26 (0xE6)
        beats = '{64'hF60A, 64'hEC14, 64'hE21E, 64'hD729};
        run_req(16'h0300, 7'd4, 1'b1, 1'b1, 4'd2, 64'h0000_0000_0000_E619, 0, 0, -1);

        // avg unsigned, K=4, shift 0, all 255 -> saturates to 255
        repeat (4) beats.push_back(64'hFFFF_FFFF_FFFF_FFFF);
        run_req(16'h0400, 7'd4, 1'b1, 1'b0, 4'd0, 64'hFFFF_FFFF_FFFF_FFFF, 0, 0, -1);

        // backpressure, max unsigned K=5: lane0 -> 0x32, lane2 -> 0x05
        beats = '{64'h01000A, 64'h020032, 64'h03001E, 64'h040014, 64'h050028};
        run_req(16'h2000, 7'd5, 1'b0, 1'b0, 4'd0, 64'h0000_0000_0005_0032, 1, 0, -1);

        // address wrap
        beats = '{64'h01, 64'h02, 64'h03, 64'h04};
        run_req(16'hFFFE, 7'd4, 1'b0, 1'b0, 4'd0, 64'h0000_0000_0000_0004, 0, 0, -1);

        // CfgK=0 behaves as a single beat pass-through
        beats = '{64'h0123_4567_89AB_CDEF};
        run_req(16'h0042, 7'd0, 1'b0, 1'b0, 4'd0, 64'h0123_4567_89AB_CDEF, 0, 1, -1);

        // K=64 avg unsigned, shift 15 clamps to 6: lane0 sum 2016 -> 31, lane1 8192 -> 128
        for (int i = 0; i < 64; i++) beats.push_back({48'h0, 8'h80, 8'(i)});
        run_req(16'h1000, 7'd64, 1'b1, 1'b0, 4'd15, 64'h0000_0000_0000_801F, 0, 1, -1);

        // reset after 2 of 4 beats, then a clean max over zero beats
        repeat (4) beats.push_back(64'hFFFF_FFFF_FFFF_FFFF);
        run_req(16'h0500, 7'd4, 1'b0, 1'b0, 4'd0, 64'h0, 0, 0, 2);
        beats = '{64'h0, 64'h0};
        run_req(16'h0600, 7'd2, 1'b0, 1'b0, 4'd0, 64'h0, 0, 1, -1);

        repeat (3) @(posedge clk);
        #1;
        check("addr_queue_drained", 64'(exp_addr_q.size()), 64'd0);
        check("out_queue_drained", 64'(exp_out_q.size()), 64'd0);
        $display("Result: errors=%0d of %0d checks", nerr, nchk);
        $finish;
    end

endmodule
